de_write_combiner: RTL and testbench

- Sits between the dithering draw engine's drawing-engine (de_*) port and the frame-store memory port.
- Accepts single-byte pixel writes (one 8-bit RRRGGGBB pixel per byte lane). Merges consecutive writes to the same 32-bit word into one buffered word.
- Issues the merged word as a single masked memory write. This cuts frame-store traffic by up to 4x on horizontal spans.
- Reads pass through, strictly ordered after any pending write.

---
 rtl/de_write_combiner.sv | 170 +++++++++++++++++
 tb/tb_de_write_combiner.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/de_write_combiner.sv
// Write combiner between the draw engine and the frame store: merges byte writes to one
// 32-bit word into a buffered word and issues it as a single masked memory write.
module de_write_combiner #(
   parameter int FLUSH_IDLE = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        de_req,
   output logic        de_ack,
   input  logic [17:0] de_addr,
   input  logic [3:0]  de_nbyte,
   input  logic        de_rnw,
   input  logic [31:0] de_w_data,
   output logic [31:0] de_r_data,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic [17:0] mem_addr,
   output logic [3:0]  mem_nbyte,
   output logic        mem_rnw,
   output logic [31:0] mem_w_data,
   input  logic [31:0] mem_r_data,
   output logic        pending
);

   localparam logic [7:0] IDLE_LAST = 8'(FLUSH_IDLE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACK,
      S_FLUSH,
      S_READ
   } state_t;

   state_t      r_state;
   logic        r_de_ack;
   logic [31:0] r_de_r_data;
   logic        r_mem_req;
   logic [17:0] r_mem_addr;
   logic [3:0]  r_mem_nbyte;
   logic        r_mem_rnw;
   logic [31:0] r_mem_w_data;

   logic [17:0] r_buf_addr;
   logic [31:0] r_buf_data;
   logic [3:0]  r_buf_en;
   logic        r_buf_valid;
   logic [7:0]  r_idle_cnt;

   logic        w_de_wr;
   logic        w_de_rd;
   logic        w_addr_hit;
   logic [3:0]  w_lane_wr;
   logic [31:0] w_merge_data;

   assign w_de_wr    = de_req & ~de_rnw;
   assign w_de_rd    = de_req & de_rnw;
   assign w_addr_hit = (de_addr == r_buf_addr);
   assign w_lane_wr  = ~de_nbyte;

   // Lanes not enabled by the current write keep their buffered byte.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_merge_data[8*gi +: 8] = w_lane_wr[gi] ? de_w_data[8*gi +: 8]
                                                        : r_buf_data[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_de_ack     <= 1'b0;
         r_de_r_data  <= 32'd0;
         r_mem_req    <= 1'b0;
         r_mem_rnw    <= 1'b0;
         r_mem_addr   <= 18'd0;
         r_mem_nbyte  <= 4'b1111;
         r_mem_w_data <= 32'd0;
         r_buf_valid  <= 1'b0;
         r_buf_en     <= 4'b0000;
         r_idle_cnt   <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_de_wr && (!r_buf_valid || w_addr_hit)) begin
                  r_buf_data  <= w_merge_data;
                  r_buf_en    <= r_buf_en | w_lane_wr;
                  r_buf_addr  <= de_addr;
                  r_buf_valid <= r_buf_valid | (de_nbyte != 4'b1111);
                  r_de_ack    <= 1'b1;
                  r_idle_cnt  <= 8'd0;
                  r_state     <= S_ACK;
               end else if (w_de_wr || (w_de_rd && r_buf_valid)) begin
                  // Buffered word must reach memory before the new request is served.
                  r_mem_req    <= 1'b1;
                  r_mem_rnw    <= 1'b0;
                  r_mem_addr   <= r_buf_addr;
                  r_mem_nbyte  <= ~r_buf_en;
                  r_mem_w_data <= r_buf_data;
                  r_state      <= S_FLUSH;
               end else if (w_de_rd) begin
                  r_mem_req   <= 1'b1;
                  r_mem_rnw   <= 1'b1;
                  r_mem_addr  <= de_addr;
                  r_mem_nbyte <= 4'b0000;
                  r_state     <= S_READ;
               end else if (r_buf_valid) begin
                  r_idle_cnt <= r_idle_cnt + 8'd1;
                  if (r_idle_cnt == IDLE_LAST) begin
                     r_mem_req    <= 1'b1;
                     r_mem_rnw    <= 1'b0;
                     r_mem_addr   <= r_buf_addr;
                     r_mem_nbyte  <= ~r_buf_en;
                     r_mem_w_data <= r_buf_data;
                     r_state      <= S_FLUSH;
                  end
               end else begin
                  r_idle_cnt <= 8'd0;
               end
            end

            S_ACK: begin
               // Requests are ignored here: the engine moves to its next transfer on this edge.
               r_de_ack <= 1'b0;
               if (r_buf_en == 4'b1111) begin
                  r_mem_req    <= 1'b1;
                  r_mem_rnw    <= 1'b0;
                  r_mem_addr   <= r_buf_addr;
                  r_mem_nbyte  <= ~r_buf_en;
                  r_mem_w_data <= r_buf_data;
                  r_state      <= S_FLUSH;
               end else begin
                  r_state <= S_IDLE;
               end
            end

            S_FLUSH: begin
               if (mem_ack) begin
                  r_mem_req   <= 1'b0;
                  r_buf_valid <= 1'b0;
                  r_buf_en    <= 4'b0000;
                  r_idle_cnt  <= 8'd0;
                  r_state     <= S_IDLE;
               end
            end

            S_READ: begin
               if (mem_ack) begin
                  r_mem_req   <= 1'b0;
                  r_de_r_data <= mem_r_data;
                  r_de_ack    <= 1'b1;
                  r_state     <= S_ACK;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign de_ack     = r_de_ack;
   assign de_r_data  = r_de_r_data;
   assign mem_req    = r_mem_req;
   assign mem_addr   = r_mem_addr;
   assign mem_nbyte  = r_mem_nbyte;
   assign mem_rnw    = r_mem_rnw;
   assign mem_w_data = r_mem_w_data;
   assign pending    = r_buf_valid | (r_state != S_IDLE);

endmodule

// File: tb/tb_de_write_combiner.sv
// Bench for de_write_combiner: directed scenarios plus random traffic checked against a
// direct-write frame-store model and a memory responder with random latency.
module tb_de_write_combiner;

   localparam int FLUSH_IDLE = 8;

   logic        clk;
   logic        rst;
   logic        de_req;
   logic        de_ack;
   logic [17:0] de_addr;
   logic [3:0]  de_nbyte;
   logic        de_rnw;
   logic [31:0] de_w_data;
   logic [31:0] de_r_data;
   logic        mem_req;
   logic        mem_ack;
   logic [17:0] mem_addr;
   logic [3:0]  mem_nbyte;
   logic        mem_rnw;
   logic [31:0] mem_w_data;
   logic [31:0] mem_r_data;
   logic        pending;

   de_write_combiner #(.FLUSH_IDLE(FLUSH_IDLE)) dut (
      .clk        (clk),
      .rst        (rst),
      .de_req     (de_req),
      .de_ack     (de_ack),
      .de_addr    (de_addr),
      .de_nbyte   (de_nbyte),
      .de_rnw     (de_rnw),
      .de_w_data  (de_w_data),
      .de_r_data  (de_r_data),
      .mem_req    (mem_req),
      .mem_ack    (mem_ack),
      .mem_addr   (mem_addr),
      .mem_nbyte  (mem_nbyte),
      .mem_rnw    (mem_rnw),
      .mem_w_data (mem_w_data),
      .mem_r_data (mem_r_data),
      .pending    (pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      logic        rnw;
      logic [3:0]  nbyte;
      logic [17:0] addr;
      logic [31:0] data;
   } txn_t;

   int          checks = 0;
   int          errors = 0;
   logic        auto_ack = 1'b1;
   txn_t        log_q[$];
   logic [31:0] ref_mem [logic [17:0]];
   logic [31:0] dut_mem [logic [17:0]];

   function automatic logic [31:0] init_word(input logic [17:0] a);
      return {a[13:0], a} ^ 32'hA5C3_0F96;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [17:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] dut_rd(input logic [17:0] a);
      return dut_mem.exists(a) ? dut_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] masked(input logic [31:0] old, input logic [3:0] nb,
                                          input logic [31:0] d);
      logic [31:0] w;
      w = old;
      for (int i = 0; i < 4; i++)
         if (!nb[i]) w[8*i +: 8] = d[8*i +: 8];
      return w;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory responder: random latency, one-cycle mem_ack, masked writes into dut_mem.
   initial begin
      logic        busy;
      int          wait_left;
      txn_t        cap;
      busy       = 1'b0;
      wait_left  = 0;
      cap        = '0;
      mem_ack    = 1'b0;
      mem_r_data = 32'd0;
      forever begin
         @(negedge clk);
         if (!auto_ack) begin
            busy = 1'b0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (rst || !mem_req) begin
            busy = 1'b0;
         end else begin
            if (!busy) begin
               busy      = 1'b1;
               cap       = '{rnw: mem_rnw, nbyte: mem_nbyte, addr: mem_addr, data: mem_w_data};
               wait_left = int'($urandom_range(0, 3));
            end
            if (wait_left == 0) begin
               chk("mem_stable", 64'({mem_rnw, mem_nbyte, mem_addr, mem_w_data}), 64'(cap));
               if (mem_rnw) mem_r_data = dut_rd(mem_addr);
               else dut_mem[mem_addr] = masked(dut_rd(mem_addr), mem_nbyte, mem_w_data);
               log_q.push_back(cap);
               $display("mem %s addr=%05h nbyte=%b data=%08h", mem_rnw ? "RD" : "WR",
                        mem_addr, mem_nbyte, mem_rnw ? mem_r_data : mem_w_data);
               mem_ack = 1'b1;
               busy    = 1'b0;
            end else begin
               wait_left--;
            end
         end
      end
   end

   task automatic do_write(input logic [17:0] a, input logic [3:0] nb, input logic [31:0] d);
      logic ok;
      ok = 1'b0;
      de_req = 1'b1; de_rnw = 1'b0; de_addr = a; de_nbyte = nb; de_w_data = d;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (de_ack) begin ok = 1'b1; break; end
      end
      chk("write_ack", 64'(ok), 64'd1);
      if (ok) ref_mem[a] = masked(ref_rd(a), nb, d);
      $display("de WR addr=%05h nbyte=%b data=%08h ack=%0d", a, nb, d, ok);
      de_req = 1'b0;
   endtask

   task automatic do_read(input logic [17:0] a);
      logic ok;
      ok = 1'b0;
      de_req = 1'b1; de_rnw = 1'b1; de_addr = a; de_nbyte = 4'b0000;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (de_ack) begin ok = 1'b1; break; end
      end
      chk("read_ack", 64'(ok), 64'd1);
      chk("read_data", 64'(de_r_data), 64'(ref_rd(a)));
      $display("de RD addr=%05h data=%08h ack=%0d", a, de_r_data, ok);
      de_req = 1'b0;
   endtask

   task automatic wait_quiet();
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (!pending && !mem_req && !mem_ack) begin ok = 1'b1; break; end
      end
      chk("quiet_timeout", 64'(ok), 64'd1);
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] prev;
      logic        seen;
      logic        ok;
      txn_t        fl;
      int          sz;
      int          cnt;
      int          r;
      logic [17:0] a;
      logic [3:0]  nb;

      rst = 1'b1; de_req = 1'b0; de_rnw = 1'b0; de_addr = '0; de_nbyte = 4'b1111;
      de_w_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_de_ack", 64'(de_ack), 64'd0);
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_rnw", 64'(mem_rnw), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_nbyte", 64'(mem_nbyte), 64'hF);
      chk("rst_mem_w_data", 64'(mem_w_data), 64'd0);
      chk("rst_de_r_data", 64'(de_r_data), 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1: four lanes of one word, then an early full-word flush
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         d[8*i +: 8] = 8'(8'h11 * (i + 1));
         nb = 4'b1111;
         nb[i] = 1'b0;
         do_write(18'h00005, nb, d);
      end
      @(negedge clk);
      chk("t1_mem_req", 64'(mem_req), 64'd1);
      chk("t1_mem_rnw", 64'(mem_rnw), 64'd0);
      chk("t1_mem_addr", 64'(mem_addr), 64'h5);
      chk("t1_mem_nbyte", 64'(mem_nbyte), 64'h0);
      chk("t1_mem_data", 64'(mem_w_data), 64'h44332211);
      wait_quiet();

      // 2: address change forces a flush before the ack, then an idle flush
      do_write(18'h00005, 4'b1110, {24'h0, 8'hAA});
      de_req = 1'b1; de_rnw = 1'b0; de_addr = 18'h00006; de_nbyte = 4'b1101;
      de_w_data = 32'h0000_BB00;
      seen = 1'b0; ok = 1'b0; fl = '0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (mem_req && !seen) begin
            seen = 1'b1;
            fl   = '{rnw: mem_rnw, nbyte: mem_nbyte, addr: mem_addr, data: mem_w_data};
         end
         if (de_ack) begin ok = 1'b1; break; end
      end
      chk("t2_flush_before_ack", 64'(seen), 64'd1);
      chk("t2_flush_addr", 64'(fl.addr), 64'h5);
      chk("t2_flush_nbyte", 64'(fl.nbyte), 64'hE);
      chk("t2_flush_byte0", 64'(fl.data[7:0]), 64'hAA);
      chk("t2_second_ack", 64'(ok), 64'd1);
      ref_mem[18'h6] = masked(ref_rd(18'h6), 4'b1101, 32'h0000_BB00);
      de_req = 1'b0;
      cnt = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (mem_req) begin cnt = n; break; end
      end
      chk("t2_idle_latency", 64'(cnt), 64'(FLUSH_IDLE + 1));
      chk("t2_idle_addr", 64'(mem_addr), 64'h6);
      chk("t2_idle_nbyte", 64'(mem_nbyte), 64'hD);
      chk("t2_idle_byte1", 64'(mem_w_data[15:8]), 64'hBB);
      wait_quiet();

      // 3: a read behind a buffered write
      sz = log_q.size();
      do_write(18'h00010, 4'b1011, 32'h005C_0000);
      do_read(18'h00010);
      chk("t3_rdata_vs_mem", 64'(de_r_data), 64'(mem_r_data));
      chk("t3_txn_count", 64'(log_q.size()), 64'(sz + 2));
      if (log_q.size() >= sz + 2) begin
         chk("t3_first_is_write", 64'({log_q[sz].rnw, log_q[sz].nbyte, log_q[sz].addr}),
             64'({1'b0, 4'b1011, 18'h00010}));
         chk("t3_second_is_read", 64'({log_q[sz+1].rnw, log_q[sz+1].addr}),
             64'({1'b1, 18'h00010}));
      end
      wait_quiet();

      // 4: request held high for 10 cycles acks every other cycle
      de_req = 1'b1; de_rnw = 1'b0; de_addr = 18'h00020; de_nbyte = 4'b0111;
      de_w_data = 32'h9D00_0000;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         chk($sformatf("t4_ack_cycle%0d", n), 64'(de_ack), 64'(n % 2));
      end
      de_req = 1'b0;
      ref_mem[18'h20] = masked(ref_rd(18'h20), 4'b0111, 32'h9D00_0000);
      wait_quiet();

      // 5: reset in the middle of a flush drops the buffered word
      auto_ack = 1'b0;
      prev = ref_rd(18'h00030);
      do_write(18'h00030, 4'b1110, 32'h0000_0077);
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (mem_req) begin seen = 1'b1; break; end
      end
      chk("t5_flush_started", 64'(seen), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_mem_req", 64'(mem_req), 64'd0);
      chk("t5_pending", 64'(pending), 64'd0);
      chk("t5_de_ack", 64'(de_ack), 64'd0);
      chk("t5_mem_nbyte", 64'(mem_nbyte), 64'hF);
      for (int k = 0; k < 3; k++) begin
         mem_ack = 1'b1;
         @(negedge clk);
         mem_ack = 1'b0;
         @(negedge clk);
         chk("t5_late_ack_req", 64'(mem_req), 64'd0);
         chk("t5_late_ack_pending", 64'(pending), 64'd0);
      end
      ref_mem[18'h30] = prev;
      auto_ack = 1'b1;

      // 6: a write with no lanes enabled is acked and leaves nothing behind
      sz = log_q.size();
      do_write(18'h00040, 4'b1111, $urandom);
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         chk("t6_pending", 64'(pending), 64'd0);
         chk("t6_mem_req", 64'(mem_req), 64'd0);
      end
      chk("t6_no_txn", 64'(log_q.size()), 64'(sz));

      // Random traffic over a few neighbouring words
      for (int k = 0; k < 150; k++) begin
         a  = 18'h00100 + 18'($urandom_range(0, 3));
         nb = 4'($urandom);
         if ($urandom_range(0, 3) == 0) do_read(a);
         else do_write(a, nb, $urandom);
         r = int'($urandom_range(0, 9));
         if (r == 0) repeat (FLUSH_IDLE + 3) @(negedge clk);
         else if (r < 4) repeat (r) @(negedge clk);
      end
      wait_quiet();
      foreach (ref_mem[ad]) chk($sformatf("final_word_%05h", ad), 64'(dut_rd(ad)),
                                64'(ref_mem[ad]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
